xor_parity_accum: RTL

//  Parametrised streaming XOR/parity unit, successor to the fixed 4-input XOR lab block.
//  Per accepted word: registered prefix-XOR vector (bit i = d[0]^...^d[i]).

---
 rtl/xor_parity_accum.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/xor_parity_accum.sv
// xor_parity_accum: streaming XOR/parity unit.
// Each accepted word produces a registered prefix-XOR vector and a one-cycle
// w_valid pulse. Across a frame, the unit accumulates total parity and word
// count, then presents the frame result on a valid/ready output.
module xor_parity_accum #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned MODE    = 0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [WIDTH-1:0]                 in_data,
  input  logic                             in_last,
  input  logic                             chk_en,
  output logic                             w_valid,
  output logic [WIDTH-1:0]                 w_prefix,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             out_parity,
  output logic [$clog2(MAX_LEN+1)-1:0]     out_cnt,
  output logic                             out_ovf,
  output logic                             out_perr
);

  localparam int unsigned CW = $clog2(MAX_LEN + 1);
  localparam logic MODE_BIT  = (MODE != 0);

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic            acc;
  logic            chk;
  logic            ovf;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_inc;
  logic            accept;
  logic            fire;
  logic            closing;
  logic            word_par;
  logic            frame_par;
  logic [WIDTH-1:0] prefix;

  // Handshake qualifiers are derived from state directly so that in_ready and
  // accept do not form a combinational loop through the FSM process.
  always_comb begin
    accept    = in_valid && (state == ACC);
    fire      = out_ready && (state == HOLD);
    cnt_inc   = cnt + CW'(1);
    closing   = in_last || (cnt_inc == CW'(MAX_LEN));
    word_par  = ^in_data;
    frame_par = acc ^ MODE_BIT;
  end

  // Running prefix-XOR of the incoming word, bit i covers in_data[i:0].
  always_comb begin
    logic run;
    run    = 1'b0;
    prefix = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      run       = run ^ in_data[i];
      prefix[i] = run;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ACC;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ACC: begin
        in_ready = 1'b1;
        if (accept && closing) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (fire) begin
          state_nxt = ACC;
        end
      end
      default: begin
        state_nxt = ACC;
      end
    endcase
  end

  // Frame accumulators: parity, word count, check flag and overflow flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= 1'b0;
      cnt <= '0;
      chk <= 1'b0;
      ovf <= 1'b0;
    end else if (fire) begin
      acc <= 1'b0;
      cnt <= '0;
      chk <= 1'b0;
      ovf <= 1'b0;
    end else if (accept) begin
      acc <= acc ^ word_par;
      cnt <= cnt_inc;
      if (cnt == '0) begin
        chk <= chk_en;
      end
      if (closing) begin
        ovf <= !in_last;
      end
    end
  end

  // Per-word prefix path: registered on every accept, no backpressure.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_valid  <= 1'b0;
      w_prefix <= '0;
    end else begin
      w_valid <= accept;
      if (accept) begin
        w_prefix <= prefix;
      end
    end
  end

  // Frame result outputs are forced to zero outside HOLD.
  always_comb begin
    out_parity = (state == HOLD) && frame_par;
    out_cnt    = (state == HOLD) ? cnt : '0;
    out_ovf    = (state == HOLD) && ovf;
    out_perr   = (state == HOLD) && chk && frame_par;
  end

endmodule
